key_entry: RTL and testbench
============================

Name: key_entry

Overview:
- Consumes the debounced scan-key event stream from the keypad scanner: a one-cycle valid pulse plus a 5-bit key code (1..20 = single key, 31 = multi-key).
- Maps codes to digits and editing commands, and accumulates up to P_DIGITS BCD digits.
- On Enter, sequentially converts the BCD buffer to binary and offers the number downstream via a valid/ready handshake.
- Also forwards function keys and auto-clears stale entries on an inactivity timeout.

Parameters:
- P_DIGITS, 4, max digits in the buffer (legal 1..8).
- P_BIN_W, 14, binary result width; the integrator sizes it ≥ ceil(log2(10^P_DIGITS)).
- P_TIMEOUT_MS, 5000, i_pls_1k pulses of inactivity before auto-clear; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset. Synchronous, active-high.
- i_pls_1k  in  1  1 kHz one-cycle tick.
- i_key_valid  in  1  one-cycle key event.
- i_key_value  in  5  key code, qualified by i_key_valid.
- i_num_ready  in  1  downstream accepts the number.
- o_bcd  out  4*P_DIGITS  entry buffer; newest digit in nibble 0.
- o_len  out  4  digits currently held (0..P_DIGITS).
- o_busy  out  1  high in S_CONV or S_VALID.
- o_num_valid  out  1  binary number available.
- o_num_bin  out  P_BIN_W  converted value.
- o_num_len  out  4  digit count of the offered number.
- o_func_valid  out  1  one-cycle function-key pulse.
- o_func_code  out  5  function key code (14..20).
- o_err  out  1  one-cycle rejected-key pulse.
- o_timeout  out  1  one-cycle auto-clear pulse.

Behaviour:
- Reset: i_rst sampled high at an edge forces state S_ENTRY and zeroes every register and output. Applies mid-conversion and mid-handshake alike.
- All outputs are registered. Effects of a key appear the cycle after the i_key_valid cycle.
- Code map:
  - 1..9 → digit 1..9; 10 → digit 0.
  - 11 → Backspace; 12 → Clear; 13 → Enter.
  - 14..20 → function key.
  - 31 → multi-key error.
  - 0 and 21..30 → ignored silently.
- Function keys, any state: o_func_valid=1 and o_func_code=code for one cycle. No other effect.
- Code 31, any state: o_err pulse, buffer untouched.
- S_ENTRY:
  - Digit with len<P_DIGITS: o_bcd ← (o_bcd<<4)|digit, len+1. Leading zeros count toward len.
  - Digit with len==P_DIGITS: ignored, o_err pulse.
  - Backspace: if len>0, o_bcd ← o_bcd>>4, len−1. If len==0, no effect and no error.
  - Clear: o_bcd←0, len←0.
  - Enter with len==0: o_err pulse, stay in S_ENTRY.
  - Enter with len>0: go to S_CONV; acc←0, nibble index←P_DIGITS−1.
- S_CONV:
  - Runs exactly P_DIGITS cycles, one nibble per cycle from MS to LS: acc ← (acc<<3)+(acc<<1)+nibble, truncated to P_BIN_W.
  - Unused upper nibbles are 0, so they contribute nothing.
  - After the last nibble, go to S_VALID with o_num_bin=acc and o_num_len=len.
  - Timing: Enter sampled at edge t → S_CONV during cycles t+1..t+P_DIGITS → o_num_valid=1 from t+P_DIGITS+1.
- S_VALID:
  - o_num_valid, o_num_bin, o_num_len and o_bcd are held stable until transfer.
  - Transfer happens on any edge with o_num_valid & i_num_ready. At the next cycle: o_num_valid=0, buffer and len cleared, state S_ENTRY.
  - i_num_ready held high beforehand transfers on the first valid cycle.
- Keys while busy (S_CONV/S_VALID):
  - Digits, Backspace and Enter are dropped with an o_err pulse.
  - Clear aborts: state→S_ENTRY, buffer cleared, o_num_valid→0, no err.
  - Clear in the same cycle as a transfer: transfer wins; the result is identical to the transfer alone.
- Timeout:
  - The ms counter runs only in S_ENTRY with len>0.
  - It zeroes on any i_key_valid, on leaving S_ENTRY, and whenever len==0.
  - Reaching P_TIMEOUT_MS: buffer and len cleared, o_timeout pulse, counter zeroed.
  - i_key_valid coincident with the terminal tick: the key is processed, the counter restarts, no timeout.
- o_err, o_func_valid and o_timeout are never asserted longer than one cycle per event.

Test Plan:
- Reset, then keys 1,2,3,Enter(13) → o_bcd=0x0123, o_len=3. o_num_valid rises 4 cycles after Enter's effect. o_num_bin=123, o_num_len=3. With i_num_ready=1 → cleared next cycle, o_len=0.
- Digits 9,9,9,9 then 5 → o_bcd=0x9999, o_err one pulse. Enter → o_num_bin=9999. Enter with len=0 → o_err, stays S_ENTRY.
- Keys 10,7,Backspace,4 → o_bcd=0x0004, o_len=2. Clear(12) → o_bcd=0, o_len=0. Backspace at len=0 → no change, no o_err.
- Enter accepted, i_num_ready=0, press digit 5 → o_err, value held. Clear with i_num_ready=1 in the same cycle → transfer occurs. Separate run: Clear alone in S_VALID → o_num_valid drops, o_len=0.
- P_TIMEOUT_MS=3: digit 1, then 3 i_pls_1k ticks → o_timeout pulse, o_len=0. Key arriving on the 3rd tick instead → no timeout.
- Codes 16 and 31 with len=2 → o_func_valid with o_func_code=16, then o_err; buffer unchanged. i_rst asserted mid-S_CONV → all outputs 0, S_ENTRY.

Source files
------------

// File: rtl/key_entry.sv
// key_entry: keypad code decoder, BCD entry buffer, BCD-to-binary converter with valid/ready output.
module key_entry #(
    parameter int P_DIGITS     = 4,
    parameter int P_BIN_W      = 14,
    parameter int P_TIMEOUT_MS = 5000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pls_1k,
    input  logic                  i_key_valid,
    input  logic [4:0]            i_key_value,
    input  logic                  i_num_ready,
    output logic [4*P_DIGITS-1:0] o_bcd,
    output logic [3:0]            o_len,
    output logic                  o_busy,
    output logic                  o_num_valid,
    output logic [P_BIN_W-1:0]    o_num_bin,
    output logic [3:0]            o_num_len,
    output logic                  o_func_valid,
    output logic [4:0]            o_func_code,
    output logic                  o_err,
    output logic                  o_timeout
);
    localparam int BW = 4 * P_DIGITS;
    localparam int TW = P_TIMEOUT_MS > 1 ? $clog2(P_TIMEOUT_MS) : 1;
    localparam logic [1:0] S_ENTRY = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [3:0] LEN_MAX = 4'(P_DIGITS);
    localparam logic [2:0] IDX_TOP = 3'(P_DIGITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT_MS - 1);

    logic [1:0]         state_q, state_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [3:0]         len_q, len_d, nlen_q, nlen_d;
    logic [P_BIN_W-1:0] acc_q, acc_d, bin_q, bin_d;
    logic [2:0]         idx_q, idx_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d, fv_q, fv_d, tmo_q, tmo_d, valid_q, busy_q;
    logic [4:0]         fc_q, fc_d;
    logic [3:0]         dig, nib;
    logic               is_dig, is_bs, is_clr, is_ent, is_fn;

    assign is_dig = i_key_valid && i_key_value >= 5'd1 && i_key_value <= 5'd10;
    assign is_bs  = i_key_valid && i_key_value == 5'd11;
    assign is_clr = i_key_valid && i_key_value == 5'd12;
    assign is_ent = i_key_valid && i_key_value == 5'd13;
    assign is_fn  = i_key_valid && i_key_value >= 5'd14 && i_key_value <= 5'd20;
    assign dig    = i_key_value == 5'd10 ? 4'd0 : i_key_value[3:0];
    assign nib    = 4'(bcd_q >> {idx_q, 2'b00});

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        len_d   = len_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        bin_d   = bin_q;
        nlen_d  = nlen_q;
        cnt_d   = '0;
        tmo_d   = 1'b0;
        fv_d    = is_fn;
        fc_d    = is_fn ? i_key_value : 5'd0;
        err_d   = i_key_valid && i_key_value == 5'd31;
        if (state_q == S_ENTRY) begin
            if (is_dig) begin
                if (len_q < LEN_MAX) begin
                    bcd_d = (bcd_q << 4) | BW'(dig);
                    len_d = len_q + 4'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (is_bs && len_q != 4'd0) begin
                bcd_d = bcd_q >> 4;
                len_d = len_q - 4'd1;
            end else if (is_clr) begin
                bcd_d = '0;
                len_d = 4'd0;
            end else if (is_ent) begin
                if (len_q == 4'd0) begin
                    err_d = 1'b1;
                end else begin
                    state_d = S_CONV;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                end
            end else if (!i_key_valid && len_q != 4'd0 && P_TIMEOUT_MS != 0) begin
                // inactivity counter: any key event restarts it, so only idle cycles count
                if (i_pls_1k && cnt_q == TMO_LAST) begin
                    bcd_d = '0;
                    len_d = 4'd0;
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = i_pls_1k ? cnt_q + TW'(1) : cnt_q;
                end
            end
        end else begin
            err_d = err_d | is_dig | is_bs | is_ent;
            // a transfer and a Clear abort land in the same place, so they share one branch
            if ((state_q == S_VALID && i_num_ready) || is_clr) begin
                state_d = S_ENTRY;
                bcd_d   = '0;
                len_d   = 4'd0;
                bin_d   = '0;
                nlen_d  = 4'd0;
            end else if (state_q == S_CONV) begin
                acc_d = (acc_q << 3) + (acc_q << 1) + P_BIN_W'(nib);
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) begin
                    state_d = S_VALID;
                    bin_d   = acc_d;
                    nlen_d  = len_q;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_ENTRY;
            bcd_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            bin_q   <= '0;
            nlen_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fv_q    <= 1'b0;
            fc_q    <= '0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            bin_q   <= bin_d;
            nlen_q  <= nlen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
            tmo_q   <= tmo_d;
            valid_q <= state_d == S_VALID;
            busy_q  <= state_d != S_ENTRY;
        end
    end

    assign o_bcd        = bcd_q;
    assign o_len        = len_q;
    assign o_busy       = busy_q;
    assign o_num_valid  = valid_q;
    assign o_num_bin    = bin_q;
    assign o_num_len    = nlen_q;
    assign o_func_valid = fv_q;
    assign o_func_code  = fc_q;
    assign o_err        = err_q;
    assign o_timeout    = tmo_q;
endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: directed test-plan sequences plus random key traffic against a digit-queue reference model.
module tb_key_entry;
    logic        clk = 1'b0, rst = 1'b1, pls = 1'b0, kv = 1'b0, rdy = 1'b0;
    logic [4:0]  kc = 5'd0;
    logic [15:0] o_bcd;
    logic [3:0]  o_len, o_num_len;
    logic [13:0] o_num_bin;
    logic [4:0]  o_func_code;
    logic        o_busy, o_num_valid, o_func_valid, o_err, o_timeout;

    key_entry #(.P_DIGITS(4), .P_BIN_W(14), .P_TIMEOUT_MS(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_pls_1k(pls), .i_key_valid(kv), .i_key_value(kc),
        .i_num_ready(rdy), .o_bcd(o_bcd), .o_len(o_len), .o_busy(o_busy),
        .o_num_valid(o_num_valid), .o_num_bin(o_num_bin), .o_num_len(o_num_len),
        .o_func_valid(o_func_valid), .o_func_code(o_func_code), .o_err(o_err),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit go = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // model: 0 entry, 1 converting, 2 offering; digits oldest first
    int q[$];
    int mst = 0, left = 0, mnum = 0, mnlen = 0, cnt = 0, e_fc = 0;
    bit e_err = 0, e_fv = 0, e_to = 0;

    function automatic int bcd_of();
        int r = 0;
        foreach (q[i]) r = (r << 4) | q[i];
        return r;
    endfunction

    function automatic int val_of();
        int r = 0;
        foreach (q[i]) r = r * 10 + q[i];
        return r % 16384;
    endfunction

    always @(posedge clk) begin
        int old_len;
        bit dg, cmd;
        e_err = 0; e_fv = 0; e_fc = 0; e_to = 0;
        if (rst) begin
            q.delete(); mst = 0; left = 0; mnum = 0; mnlen = 0; cnt = 0; go = 1'b1;
        end else begin
            dg  = kv && kc >= 1 && kc <= 10;
            cmd = kv && (kc == 11 || kc == 13);
            if (kv && kc >= 14 && kc <= 20) begin e_fv = 1; e_fc = kc; end
            if (kv && kc == 31) e_err = 1;
            old_len = q.size();
            if (mst == 0) begin
                if (dg) begin
                    if (q.size() < 4) q.push_back(kc == 10 ? 0 : int'(kc)); else e_err = 1;
                end else if (kv && kc == 11) begin
                    if (q.size() > 0) void'(q.pop_back());
                end else if (kv && kc == 12) begin
                    q.delete();
                end else if (kv && kc == 13) begin
                    if (q.size() == 0) e_err = 1; else begin mst = 1; left = 4; end
                end
                if (kv || old_len == 0) cnt = 0;
                else if (pls) begin
                    if (cnt == 2) begin q.delete(); e_to = 1; cnt = 0; end else cnt++;
                end
            end else begin
                cnt = 0;
                if (dg || cmd) e_err = 1;
                if ((mst == 2 && rdy) || (kv && kc == 12)) begin
                    mst = 0; q.delete();
                end else if (mst == 1) begin
                    left--;
                    if (left == 0) begin mst = 2; mnum = val_of(); mnlen = q.size(); end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            check("bcd", o_bcd, bcd_of());
            check("len", o_len, q.size());
            check("busy", o_busy, mst != 0);
            check("num_valid", o_num_valid, mst == 2);
            if (mst == 2) begin
                check("num_bin", o_num_bin, mnum);
                check("num_len", o_num_len, mnlen);
            end
            check("err", o_err, e_err);
            check("func_valid", o_func_valid, e_fv);
            check("func_code", o_func_code, e_fc);
            check("timeout", o_timeout, e_to);
        end
    end

    task automatic cyc(input logic k, input logic [4:0] c, input logic p, input logic r);
        kv = k; kc = c; pls = p; rdy = r;
        @(negedge clk);
    endtask

    task automatic key(input logic [4:0] c);
        cyc(1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) cyc(1'b0, 5'd0, 1'b0, r);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        key(1); key(2); key(3); cyc(1'b1, 5'd13, 1'b0, 1'b1); idle(7, 1'b1);
        key(9); key(9); key(9); key(9); key(5); key(13); idle(8, 1'b0); idle(2, 1'b1);
        key(13); idle(1, 1'b0);
        key(10); key(7); key(11); key(4); key(12); key(11); idle(1, 1'b0);
        key(4); key(2); key(13); idle(6, 1'b0); key(5); idle(1, 1'b0);
        cyc(1'b1, 5'd12, 1'b0, 1'b1); idle(2, 1'b0);
        key(8); key(13); idle(6, 1'b0); key(12); idle(2, 1'b0);
        key(1); cyc(1'b0, 5'd0, 1'b1, 1'b0); idle(1, 1'b0);
        cyc(1'b0, 5'd0, 1'b1, 1'b0); cyc(1'b0, 5'd0, 1'b1, 1'b0); idle(2, 1'b0);
        key(2); cyc(1'b0, 5'd0, 1'b1, 1'b0); cyc(1'b0, 5'd0, 1'b1, 1'b0);
        cyc(1'b1, 5'd3, 1'b1, 1'b0); cyc(1'b0, 5'd0, 1'b1, 1'b0); key(12);
        key(5); key(6); key(16); key(31); idle(1, 1'b0);
        key(13); idle(2, 1'b0); rst = 1'b1; idle(1, 1'b0); rst = 1'b0; idle(2, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [4:0] c;
            r = $urandom_range(0, 15);
            c = r < 10 ? 5'(r + 1) : r == 10 ? 5'd11 : r == 11 ? 5'd12 : r == 12 ? 5'd13 :
                r == 13 ? 5'(14 + $urandom_range(0, 6)) : r == 14 ? 5'd31 :
                ($urandom_range(0, 1) == 1 ? 5'(21 + $urandom_range(0, 9)) : 5'd0);
            rst = $urandom_range(0, 499) == 0;
            cyc($urandom_range(0, 3) == 0, c, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end
        rst = 1'b0;
        idle(3, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
